// File: rtl/apb_master_if.sv
// Bundles the command/response handshake and the APB requester/completer signals
// of apb_master; the master modport is the controller's view, slave the environment's.
interface apb_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_slverr;
  logic              rsp_timeout;
  logic [ADDR_W-1:0] paddr;
  logic              pselx;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic              pready;
  logic              pslverr;
  logic [DATA_W-1:0] prdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, pready, pslverr, prdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
           paddr, pselx, penable, pwrite, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, pready, pslverr, prdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
           paddr, pselx, penable, pwrite, pwdata
  );
endinterface

// File: rtl/apb_master.sv
// APB requester: turns one command at a time into an APB SETUP/ACCESS transfer,
// with a bounded ACCESS wait and a one-cycle completion pulse carrying the result.
module apb_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          pclk,
  input  logic          prst,
  apb_master_if.master  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t            r_state;
  state_t            w_next;
  logic [7:0]        r_cnt;
  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_slverr;
  logic              r_rsp_timeout;

  logic              w_ok;
  logic              w_tmo;
  logic              w_end;
  logic              w_cmd_ready;
  logic              w_accept;

  // pready on the final counted cycle is a normal completion, not a timeout
  always_comb begin
    w_ok        = 1'b0;
    w_tmo       = 1'b0;
    w_end       = 1'b0;
    w_cmd_ready = 1'b0;
    w_accept    = 1'b0;
    w_next      = r_state;

    if (r_state == ST_ACCESS) begin
      w_ok  = bus.pready;
      w_tmo = !bus.pready && (r_cnt == CNT_LAST);
    end
    w_end       = w_ok || w_tmo;
    w_cmd_ready = (r_state == ST_IDLE) || w_end;
    w_accept    = bus.cmd_valid && w_cmd_ready;

    case (r_state)
      ST_IDLE:   if (w_accept) w_next = ST_SETUP;
      ST_SETUP:  w_next = ST_ACCESS;
      ST_ACCESS: if (w_end) w_next = w_accept ? ST_SETUP : ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // APB strobes follow the next state so they are registered, not decoded
  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_cnt         <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_slverr  <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_psel    <= (w_next != ST_IDLE);
      r_penable <= (w_next == ST_ACCESS);

      if (w_accept) begin
        r_paddr  <= bus.cmd_addr;
        r_pwrite <= bus.cmd_write;
        r_pwdata <= bus.cmd_wdata;
      end

      if (r_state == ST_SETUP) begin
        r_cnt <= '0;
      end else if ((r_state == ST_ACCESS) && !bus.pready) begin
        r_cnt <= r_cnt + 8'd1;
      end

      r_rsp_valid <= w_end;
      if (w_end) begin
        r_rsp_rdata   <= (w_ok && !r_pwrite) ? bus.prdata : '0;
        r_rsp_slverr  <= w_ok ? bus.pslverr : 1'b1;
        r_rsp_timeout <= w_tmo;
      end
    end
  end

  assign bus.cmd_ready   = w_cmd_ready;
  assign bus.paddr       = r_paddr;
  assign bus.pselx       = r_psel;
  assign bus.penable     = r_penable;
  assign bus.pwrite      = r_pwrite;
  assign bus.pwdata      = r_pwdata;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_rdata   = r_rsp_rdata;
  assign bus.rsp_slverr  = r_rsp_slverr;
  assign bus.rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master (TIMEOUT=4): a vector table of single transfers
// plus hand sequences for back-to-back commands and reset during ACCESS.
module tb_apb_master;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 4;

  logic pclk;
  logic prst;
  int   n_err;
  int   n_chk;

  apb_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .pclk (pclk),
    .prst (prst),
    .bus  (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] prdata;
    logic          slv;
    int            waits;
    int            exp_acc;
    logic [DW-1:0] exp_rdata;
    logic          exp_slv;
    logic          exp_to;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int acc;
    bit done;
    acc  = 0;
    done = 1'b0;
    @(negedge pclk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = v.wr;
    bus.cmd_addr  = v.addr;
    bus.cmd_wdata = v.wdata;
    bus.pready    = 1'b0;
    #1;
    check($sformatf("v%0d_ready_idle", idx), bus.cmd_ready, 1);
    @(negedge pclk);
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = ~v.addr;
    bus.cmd_wdata = ~v.wdata;
    #1;
    check($sformatf("v%0d_setup_psel", idx), bus.pselx, 1);
    check($sformatf("v%0d_setup_pen", idx), bus.penable, 0);
    check($sformatf("v%0d_setup_ready", idx), bus.cmd_ready, 0);
    check($sformatf("v%0d_setup_addr", idx), bus.paddr, v.addr);
    check($sformatf("v%0d_setup_wr", idx), bus.pwrite, v.wr);
    check($sformatf("v%0d_setup_wdata", idx), bus.pwdata, v.wdata);
    for (int k = 0; k < 40; k++) begin
      @(negedge pclk);
      if (bus.rsp_valid === 1'b1) begin
        done = 1'b1;
        break;
      end
      if (!(bus.pselx === 1'b1 && bus.penable === 1'b1)) begin
        check($sformatf("v%0d_access_strobes", idx), {bus.pselx, bus.penable}, 2'b11);
        break;
      end
      acc++;
      check($sformatf("v%0d_acc_addr", idx), bus.paddr, v.addr);
      check($sformatf("v%0d_acc_wdata", idx), bus.pwdata, v.wdata);
      bus.pready  = (acc > v.waits);
      bus.prdata  = bus.pready ? v.prdata : ~v.prdata;
      bus.pslverr = bus.pready ? v.slv : ~v.slv;
      #1;
      check($sformatf("v%0d_acc_ready", idx), bus.cmd_ready,
            (bus.pready || (acc - 1 == TMO - 1)) ? 1 : 0);
    end
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    check($sformatf("v%0d_rsp_seen", idx), done, 1);
    check($sformatf("v%0d_acc_cycles", idx), acc, v.exp_acc);
    check($sformatf("v%0d_rdata", idx), bus.rsp_rdata, v.exp_rdata);
    check($sformatf("v%0d_slverr", idx), bus.rsp_slverr, v.exp_slv);
    check($sformatf("v%0d_timeout", idx), bus.rsp_timeout, v.exp_to);
    check($sformatf("v%0d_idle_psel", idx), {bus.pselx, bus.penable}, 2'b00);
    @(negedge pclk);
    check($sformatf("v%0d_pulse_end", idx), bus.rsp_valid, 0);
    check($sformatf("v%0d_rdata_hold", idx), bus.rsp_rdata, v.exp_rdata);
    check($sformatf("v%0d_slverr_hold", idx), bus.rsp_slverr, v.exp_slv);
  endtask

  initial begin
    int pulses;
    n_err = 0;
    n_chk = 0;
    vecs[0] = '{1'b1, 32'h1,      32'd24,       32'h0,        1'b0, 0,   1, 32'h0,        1'b0, 1'b0};
    vecs[1] = '{1'b0, 32'h3,      32'h0,        32'd26,       1'b0, 3,   4, 32'd26,       1'b0, 1'b0};
    vecs[2] = '{1'b0, 32'h5,      32'h0,        32'h55,       1'b1, 0,   1, 32'h55,       1'b1, 1'b0};
    vecs[3] = '{1'b0, 32'h7,      32'h0,        32'hAA,       1'b0, 100, 4, 32'h0,        1'b1, 1'b1};
    vecs[4] = '{1'b1, 32'hABCD,   32'h1234_5678, 32'h0,       1'b1, 2,   3, 32'h0,        1'b1, 1'b0};
    vecs[5] = '{1'b0, 32'h10,     32'h0,        32'hDEAD_BEEF, 1'b0, 1,  2, 32'hDEAD_BEEF, 1'b0, 1'b0};

    prst          = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;
    bus.prdata    = '0;
    repeat (3) @(negedge pclk);
    check("rst_psel", bus.pselx, 0);
    check("rst_pen", bus.penable, 0);
    check("rst_pwrite", bus.pwrite, 0);
    check("rst_paddr", bus.paddr, 0);
    check("rst_pwdata", bus.pwdata, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_rdata", bus.rsp_rdata, 0);
    check("rst_rsp_slverr", bus.rsp_slverr, 0);
    check("rst_rsp_timeout", bus.rsp_timeout, 0);
    check("rst_cmd_ready", bus.cmd_ready, 1);
    prst = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Back-to-back writes with cmd_valid held
    pulses = 0;
    @(negedge pclk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 32'h20;
    bus.cmd_wdata = 32'h111;
    bus.pready    = 1'b1;
    @(negedge pclk);
    check("b2b_s1_strobes", {bus.pselx, bus.penable}, 2'b10);
    check("b2b_s1_addr", bus.paddr, 32'h20);
    bus.cmd_addr  = 32'h24;
    bus.cmd_wdata = 32'h222;
    @(negedge pclk);
    check("b2b_a1_strobes", {bus.pselx, bus.penable}, 2'b11);
    check("b2b_a1_addr", bus.paddr, 32'h20);
    check("b2b_a1_wdata", bus.pwdata, 32'h111);
    @(negedge pclk);
    if (bus.rsp_valid === 1'b1) pulses++;
    check("b2b_s2_strobes", {bus.pselx, bus.penable}, 2'b10);
    check("b2b_s2_addr", bus.paddr, 32'h24);
    bus.cmd_valid = 1'b0;
    @(negedge pclk);
    if (bus.rsp_valid === 1'b1) pulses++;
    check("b2b_a2_strobes", {bus.pselx, bus.penable}, 2'b11);
    check("b2b_a2_wdata", bus.pwdata, 32'h222);
    @(negedge pclk);
    if (bus.rsp_valid === 1'b1) pulses++;
    check("b2b_end_strobes", {bus.pselx, bus.penable}, 2'b00);
    bus.pready = 1'b0;
    @(negedge pclk);
    if (bus.rsp_valid === 1'b1) pulses++;
    check("b2b_pulses", pulses, 2);

    // Reset asserted in the middle of ACCESS
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h40;
    @(negedge pclk);
    bus.cmd_valid = 1'b0;
    @(negedge pclk);
    check("rstmid_in_access", {bus.pselx, bus.penable}, 2'b11);
    #2 prst = 1'b0;
    #1;
    check("rstmid_strobes", {bus.pselx, bus.penable}, 2'b00);
    check("rstmid_paddr", bus.paddr, 0);
    check("rstmid_rsp_valid", bus.rsp_valid, 0);
    @(negedge pclk);
    bus.pready = 1'b1;
    @(negedge pclk);
    check("rstmid_no_rsp", bus.rsp_valid, 0);
    bus.pready = 1'b0;
    prst = 1'b1;
    @(negedge pclk);
    check("rstmid_no_rsp_after", bus.rsp_valid, 0);
    run_vec(vecs[5], 6);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
